// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync and blanking
// flags all derived from the next-state counters so they line up with pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ACT = 1'(SYNC_POL);

  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       hs_active;
  logic       vs_active;

  // Next raster position; the line counter only advances on the horizontal wrap.
  always_comb begin
    next_x = pixel_x + 10'd1;
    next_y = pixel_y;
    if (pixel_x == H_LAST) begin
      next_x = 10'd0;
      if (pixel_y == V_LAST) begin
        next_y = 10'd0;
      end else begin
        next_y = pixel_y + 10'd1;
      end
    end
  end

  always_comb begin
    hs_active = (next_x >= HS_START) && (next_x <= HS_END);
    vs_active = (next_y >= VS_START) && (next_y <= VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else if (en) begin
      pixel_x     <= next_x;
      pixel_y     <= next_y;
      hsync       <= hs_active ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= vs_active ? SYNC_ACT : ~SYNC_ACT;
      video_on    <= (next_x < H_VIS_W) && (next_y < V_VIS_W);
      // Only reachable by wrapping, so the reset-held origin never pulses.
      frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
      line_end    <= (next_x == H_LAST);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: a default-timing instance and a tiny SYNC_POL=1 instance,
// both compared every cycle against a raster model driven by an enabled-cycle count.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] xa, ya, xb, yb;
  logic       hsa, vsa, vona, fsa, lea;
  logic       hsb, vsb, vonb, fsb, leb;
  logic [24:0] out_a, out_b;

  int tests = 0;
  int fails = 0;
  int na = 0;
  int nb = 0;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_x(xa), .pixel_y(ya), .hsync(hsa), .vsync(vsa),
    .video_on(vona), .frame_start(fsa), .line_end(lea)
  );

  vga_sync_gen #(
    .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_x(xb), .pixel_y(yb), .hsync(hsb), .vsync(vsb),
    .video_on(vonb), .frame_start(fsb), .line_end(leb)
  );

  assign out_a = {xa, ya, hsa, vsa, vona, fsa, lea};
  assign out_b = {xb, yb, hsb, vsb, vonb, fsb, leb};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raster position is simply the enabled-cycle count folded into a frame.
  function automatic logic [24:0] model(input int n, input int hv, input int hf,
                                        input int hsw, input int hb, input int vv,
                                        input int vf, input int vsw, input int vb,
                                        input int pol);
    int ht, vt, pos, x, y;
    logic p, hs, vs, von, fs, le;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    pos = n % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    p   = pol[0];
    hs  = (x >= hv + hf && x < hv + hf + hsw) ? p : ~p;
    vs  = (y >= vv + vf && y < vv + vf + vsw) ? p : ~p;
    von = (n > 0) && (x < hv) && (y < vv);
    fs  = (n > 0) && (pos == 0);
    le  = (x == ht - 1);
    return {10'(x), 10'(y), hs, vs, von, fs, le};
  endfunction

  function automatic logic [24:0] model_a(input int n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0);
  endfunction

  function automatic logic [24:0] model_b(input int n);
    return model(n, 20, 3, 5, 4, 10, 2, 2, 3, 1);
  endfunction

  task automatic checkOutput(input string name, input logic [24:0] act, input logic [24:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got x=%0d y=%0d hs/vs/von/fs/le=%b, expected x=%0d y=%0d hs/vs/von/fs/le=%b",
               name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en_v);
    en = en_v;
    @(posedge clk);
    if (en_v) begin
      na++;
      nb++;
    end
    #1;
    checkOutput("cycle_a", out_a, model_a(na));
    checkOutput("cycle_b", out_b, model_b(nb));
  endtask

  // Pulls reset between clock edges and checks outputs before any edge arrives.
  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    na = 0;
    nb = 0;
    checkOutput("async_rst_a", out_a, {10'd0, 10'd0, 5'b11000});
    checkOutput("async_rst_b", out_b, {10'd0, 10'd0, 5'b00000});
    #3 rst_n = 1'b1;
  endtask

  typedef struct {
    int         adv;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt, fs_cnt, fs_at, vs_cnt, von_cnt;
    logic seen;

    vecs[0] = '{1,   10'd1,   10'd0, 5'b11100};
    vecs[1] = '{638, 10'd639, 10'd0, 5'b11100};
    vecs[2] = '{1,   10'd640, 10'd0, 5'b11000};
    vecs[3] = '{16,  10'd656, 10'd0, 5'b01000};
    vecs[4] = '{95,  10'd751, 10'd0, 5'b01000};
    vecs[5] = '{1,   10'd752, 10'd0, 5'b11000};
    vecs[6] = '{47,  10'd799, 10'd0, 5'b11001};
    vecs[7] = '{1,   10'd0,   10'd1, 5'b11100};

    rst_n = 1'b0;
    en    = 1'b0;
    #12;
    checkOutput("reset_a", out_a, {10'd0, 10'd0, 5'b11000});
    checkOutput("reset_b", out_b, {10'd0, 10'd0, 5'b00000});
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      repeat (vecs[i].adv) applyStimulus(1'b1);
      checkOutput($sformatf("vec%0d", i), out_a, {vecs[i].x, vecs[i].y, vecs[i].flags});
    end

    // Freeze at pixel_x=300, then time the next line_end.
    repeat (300) applyStimulus(1'b1);
    checkOutput("pre_freeze", out_a, {10'd300, 10'd1, 5'b11100});
    repeat (37) applyStimulus(1'b0);
    checkOutput("frozen", out_a, {10'd300, 10'd1, 5'b11100});
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 1000) begin
      applyStimulus(1'b1);
      cnt++;
      seen = lea;
    end
    checkInt("line_end_after_resume", cnt, 499);

    // Full frame on the small instance after a mid-line asynchronous reset.
    repeat (7) applyStimulus(1'b1);
    asyncReset();
    fs_cnt  = 0;
    fs_at   = -1;
    vs_cnt  = 0;
    von_cnt = 0;
    for (int c = 1; c <= 544; c++) begin
      applyStimulus(1'b1);
      if (fsb) begin
        fs_cnt++;
        fs_at = c;
      end
      if (vsb) vs_cnt++;
      if (vonb) von_cnt++;
    end
    checkInt("frame_start_count", fs_cnt, 1);
    checkInt("frame_start_cycle", fs_at, 544);
    checkInt("vsync_active_cycles", vs_cnt, 64);
    checkInt("video_on_cycles", von_cnt, 200);

    // Random enable pattern with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) asyncReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
